// File: rtl/sd_spi_responder_if.sv
// SPI-side signal bundle for the SD card responder: host-driven bus lines plus
// the card's decoded-command and status outputs.
interface sd_spi_responder_if;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        card_ready;

    modport master (
        output sclk, cs_n, mosi,
        input  miso, cmd_valid, cmd_index, cmd_arg, card_ready
    );

    modport slave (
        input  sclk, cs_n, mosi,
        output miso, cmd_valid, cmd_index, cmd_arg, card_ready
    );
endinterface

// File: rtl/sd_spi_responder.sv
// SD card SPI-mode command responder: oversamples the host SPI bus on clk, decodes
// 48-bit command frames, and answers with R1/R3/R7 after a one-byte Ncr gap.
module sd_spi_responder #(
    parameter int unsigned BUSY_COUNT = 2,
    parameter logic [23:0] OCR_VOLT   = 24'hFF8000
) (
    input logic               clk,
    input logic               rst,
    sd_spi_responder_if.slave spi
);

    localparam int unsigned CntW = (BUSY_COUNT < 1) ? 1 : $clog2(BUSY_COUNT + 1);

    typedef enum logic [1:0] {
        StHunt,
        StCmd,
        StGap,
        StResp
    } state_e;

    // Input synchronizers and sclk edge detection
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic cs_meta_q, cs_sync_q;
    logic mosi_meta_q, mosi_sync_q;
    logic sclk_rise, sclk_fall;

    state_e          state_q, state_d;
    logic [5:0]      bit_cnt_q, bit_cnt_d;
    logic [37:0]     payload_q, payload_d;
    logic [39:0]     resp_q, resp_d;
    logic [5:0]      last_q, last_d;
    logic            miso_q, miso_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic [5:0]      cmd_index_q, cmd_index_d;
    logic [31:0]     cmd_arg_q, cmd_arg_d;
    logic            ready_q, ready_d;
    logic            idle_q, idle_d;
    logic            app_q, app_d;
    logic [CntW-1:0] acmd_cnt_q, acmd_cnt_d;

    // Command decode results
    logic [5:0]      dec_index;
    logic [31:0]     dec_arg;
    logic            idle_upd, ready_upd, app_upd, illegal, long_resp;
    logic [CntW-1:0] cnt_upd;
    logic [31:0]     resp_tail;
    logic [7:0]      r1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            mosi_meta_q <= 1'b1;
            mosi_sync_q <= 1'b1;
        end else begin
            sclk_meta_q <= spi.sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= spi.cs_n;
            cs_sync_q   <= cs_meta_q;
            mosi_meta_q <= spi.mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;

    // Only bits 3..40 (index and argument) are kept; CRC and stop bit are never stored.
    assign dec_index = payload_q[37:32];
    assign dec_arg   = payload_q[31:0];

    always_comb begin
        idle_upd  = idle_q;
        ready_upd = ready_q;
        cnt_upd   = acmd_cnt_q;
        app_upd   = 1'b0;
        illegal   = 1'b0;
        long_resp = 1'b0;
        resp_tail = 32'h0;
        case (dec_index)
            6'd0: begin
                idle_upd  = 1'b1;
                ready_upd = 1'b0;
                cnt_upd   = '0;
            end
            6'd8: begin
                long_resp = 1'b1;
                resp_tail = {16'h0000, 4'h0, dec_arg[11:8], dec_arg[7:0]};
            end
            6'd55: app_upd = 1'b1;
            6'd41: begin
                if (!app_q) begin
                    illegal = 1'b1;
                end else if (32'(acmd_cnt_q) < BUSY_COUNT) begin
                    cnt_upd = acmd_cnt_q + CntW'(1);
                end else begin
                    idle_upd  = 1'b0;
                    ready_upd = 1'b1;
                end
            end
            6'd58: begin
                long_resp = 1'b1;
                resp_tail = {ready_q, ready_q, 6'h00, OCR_VOLT};
            end
            default: illegal = 1'b1;
        endcase
    end

    // Idle bit reflects the post-command state, so CMD0 and the final ACMD41 report it directly.
    assign r1 = {5'b00000, illegal, 1'b0, idle_upd};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        payload_d   = payload_q;
        resp_d      = resp_q;
        last_d      = last_q;
        miso_d      = miso_q;
        cmd_valid_d = 1'b0;
        cmd_index_d = cmd_index_q;
        cmd_arg_d   = cmd_arg_q;
        ready_d     = ready_q;
        idle_d      = idle_q;
        app_d       = app_q;
        acmd_cnt_d  = acmd_cnt_q;

        if (cs_sync_q) begin
            state_d   = StHunt;
            bit_cnt_d = 6'd0;
            miso_d    = 1'b1;
        end else begin
            unique case (state_q)
                StHunt: begin
                    miso_d = 1'b1;
                    if (sclk_rise && !mosi_sync_q) begin
                        state_d   = StCmd;
                        bit_cnt_d = 6'd1;
                    end
                end
                StCmd: begin
                    if (sclk_rise) begin
                        if (bit_cnt_q >= 6'd2 && bit_cnt_q <= 6'd39) begin
                            payload_d = {payload_q[36:0], mosi_sync_q};
                        end
                        if (bit_cnt_q == 6'd47) begin
                            state_d     = StGap;
                            bit_cnt_d   = 6'd0;
                            cmd_valid_d = 1'b1;
                            cmd_index_d = dec_index;
                            cmd_arg_d   = dec_arg;
                            idle_d      = idle_upd;
                            ready_d     = ready_upd;
                            app_d       = app_upd;
                            acmd_cnt_d  = cnt_upd;
                            resp_d      = {r1, resp_tail};
                            last_d      = long_resp ? 6'd39 : 6'd7;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end
                end
                StGap: begin
                    miso_d = 1'b1;
                    if (sclk_rise) begin
                        if (bit_cnt_q == 6'd7) begin
                            state_d   = StResp;
                            bit_cnt_d = 6'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end
                end
                StResp: begin
                    if (sclk_fall) begin
                        miso_d = resp_q[39];
                        resp_d = {resp_q[38:0], 1'b1};
                    end else if (sclk_rise) begin
                        if (bit_cnt_q == last_q) begin
                            state_d   = StHunt;
                            bit_cnt_d = 6'd0;
                            miso_d    = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end
                end
                default: begin
                    state_d = StHunt;
                    miso_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StHunt;
            bit_cnt_q   <= 6'd0;
            payload_q   <= '0;
            resp_q      <= '1;
            last_q      <= 6'd0;
            miso_q      <= 1'b1;
            cmd_valid_q <= 1'b0;
            cmd_index_q <= 6'd0;
            cmd_arg_q   <= 32'h0;
            ready_q     <= 1'b0;
            idle_q      <= 1'b1;
            app_q       <= 1'b0;
            acmd_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            payload_q   <= payload_d;
            resp_q      <= resp_d;
            last_q      <= last_d;
            miso_q      <= miso_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_index_q <= cmd_index_d;
            cmd_arg_q   <= cmd_arg_d;
            ready_q     <= ready_d;
            idle_q      <= idle_d;
            app_q       <= app_d;
            acmd_cnt_q  <= acmd_cnt_d;
        end
    end

    assign spi.miso       = miso_q;
    assign spi.cmd_valid  = cmd_valid_q;
    assign spi.cmd_index  = cmd_index_q;
    assign spi.cmd_arg    = cmd_arg_q;
    assign spi.card_ready = ready_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: drives SPI mode-0 host transactions and
// checks R1/R3/R7 bytes, cmd_valid pulses and card state.
module tb_sd_spi_responder;

    localparam int HALF = 50;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   valid_cnt = 0;

    sd_spi_responder_if bus ();

    sd_spi_responder #(
        .BUSY_COUNT(2),
        .OCR_VOLT  (24'hFF8000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .spi(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.cmd_valid === 1'b1) valid_cnt <= valid_cnt + 1;
    end

    function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, 8'h01};
    endfunction

    task automatic spi_bit(input logic b, output logic r);
        bus.mosi = b;
        #HALF;
        bus.sclk = 1'b1;
        r = bus.miso;
        #HALF;
        bus.sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic xfer(input logic [47:0] frame, input int nbytes,
                        output logic [7:0] gap, output logic [39:0] resp);
        logic [7:0] b;
        bus.cs_n = 1'b0;
        #(2 * HALF);
        for (int i = 5; i >= 0; i--) spi_byte(frame[i*8 +: 8], b);
        spi_byte(8'hFF, gap);
        resp = '0;
        for (int i = 0; i < nbytes; i++) begin
            spi_byte(8'hFF, b);
            resp = {resp[31:0], b};
        end
        bus.mosi = 1'b1;
        bus.cs_n = 1'b1;
        #(4 * HALF);
    endtask

    task automatic test_reset;
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.miso !== 1'b1) begin
            $display("FAIL reset_miso: got %b want 1", bus.miso); n_fail++;
        end
        n_checks++;
        if (bus.cmd_valid !== 1'b0) begin
            $display("FAIL reset_cmd_valid: got %b want 0", bus.cmd_valid); n_fail++;
        end
        n_checks++;
        if (bus.cmd_index !== 6'd0) begin
            $display("FAIL reset_cmd_index: got %0d want 0", bus.cmd_index); n_fail++;
        end
        n_checks++;
        if (bus.cmd_arg !== 32'h0) begin
            $display("FAIL reset_cmd_arg: got %h want 0", bus.cmd_arg); n_fail++;
        end
        n_checks++;
        if (bus.card_ready !== 1'b0) begin
            $display("FAIL reset_card_ready: got %b want 0", bus.card_ready); n_fail++;
        end
    endtask

    task automatic test_cmd0;
        logic [7:0] gap; logic [39:0] resp; int v0;
        v0 = valid_cnt;
        xfer(48'h40_0000_0000_95, 1, gap, resp);
        n_checks++;
        if (gap !== 8'hFF) begin
            $display("FAIL cmd0_gap: got %h want ff", gap); n_fail++;
        end
        n_checks++;
        if (resp[7:0] !== 8'h01) begin
            $display("FAIL cmd0_r1: got %h want 01", resp[7:0]); n_fail++;
        end
        n_checks++;
        if (valid_cnt !== v0 + 1) begin
            $display("FAIL cmd0_valid_pulses: got %0d want 1", valid_cnt - v0); n_fail++;
        end
        n_checks++;
        if (bus.cmd_index !== 6'd0) begin
            $display("FAIL cmd0_index: got %0d want 0", bus.cmd_index); n_fail++;
        end
    endtask

    task automatic test_cmd8;
        logic [7:0] gap; logic [39:0] resp;
        xfer(48'h48_0000_01AA_87, 5, gap, resp);
        n_checks++;
        if (gap !== 8'hFF) begin
            $display("FAIL cmd8_gap: got %h want ff", gap); n_fail++;
        end
        n_checks++;
        if (resp !== 40'h01_0000_01AA) begin
            $display("FAIL cmd8_r7: got %h want 01000001aa", resp); n_fail++;
        end
        n_checks++;
        if (bus.cmd_index !== 6'd8) begin
            $display("FAIL cmd8_index: got %0d want 8", bus.cmd_index); n_fail++;
        end
        n_checks++;
        if (bus.cmd_arg !== 32'h0000_01AA) begin
            $display("FAIL cmd8_arg: got %h want 000001aa", bus.cmd_arg); n_fail++;
        end
    endtask

    task automatic test_cmd58_idle;
        logic [7:0] gap; logic [39:0] resp;
        xfer(make_frame(6'd58, 32'h0), 5, gap, resp);
        n_checks++;
        if (resp !== 40'h01_00FF_8000) begin
            $display("FAIL cmd58_idle_r3: got %h want 0100ff8000", resp); n_fail++;
        end
    endtask

    task automatic test_illegal;
        logic [7:0] gap; logic [39:0] resp;
        xfer(make_frame(6'd41, 32'h4000_0000), 1, gap, resp);
        n_checks++;
        if (resp[7:0] !== 8'h05) begin
            $display("FAIL cmd41_no_app: got %h want 05", resp[7:0]); n_fail++;
        end
        xfer(make_frame(6'd5, 32'h0), 1, gap, resp);
        n_checks++;
        if (resp[7:0] !== 8'h05) begin
            $display("FAIL cmd5_illegal: got %h want 05", resp[7:0]); n_fail++;
        end
    endtask

    task automatic test_app_clear;
        logic [7:0] gap; logic [39:0] resp;
        xfer(make_frame(6'd55, 32'h0), 1, gap, resp);
        n_checks++;
        if (resp[7:0] !== 8'h01) begin
            $display("FAIL app_clear_cmd55: got %h want 01", resp[7:0]); n_fail++;
        end
        xfer(48'h48_0000_01AA_87, 5, gap, resp);
        n_checks++;
        if (resp[39:32] !== 8'h01) begin
            $display("FAIL app_clear_cmd8: got %h want 01", resp[39:32]); n_fail++;
        end
        xfer(make_frame(6'd41, 32'h4000_0000), 1, gap, resp);
        n_checks++;
        if (resp[7:0] !== 8'h05) begin
            $display("FAIL app_clear_cmd41: got %h want 05", resp[7:0]); n_fail++;
        end
    endtask

    task automatic test_acmd41;
        logic [7:0] gap; logic [39:0] resp;
        logic [7:0] exp_r1 [3];
        logic       exp_rdy [3];
        exp_r1[0] = 8'h01; exp_r1[1] = 8'h01; exp_r1[2] = 8'h00;
        exp_rdy[0] = 1'b0; exp_rdy[1] = 1'b0; exp_rdy[2] = 1'b1;
        xfer(48'h40_0000_0000_95, 1, gap, resp);
        for (int i = 0; i < 3; i++) begin
            xfer(make_frame(6'd55, 32'h0), 1, gap, resp);
            n_checks++;
            if (resp[7:0] !== 8'h01) begin
                $display("FAIL acmd41_cmd55_%0d: got %h want 01", i, resp[7:0]); n_fail++;
            end
            xfer(make_frame(6'd41, 32'h4000_0000), 1, gap, resp);
            n_checks++;
            if (resp[7:0] !== exp_r1[i]) begin
                $display("FAIL acmd41_r1_%0d: got %h want %h", i, resp[7:0], exp_r1[i]);
                n_fail++;
            end
            n_checks++;
            if (bus.card_ready !== exp_rdy[i]) begin
                $display("FAIL acmd41_ready_%0d: got %b want %b", i, bus.card_ready, exp_rdy[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_cmd58_ready;
        logic [7:0] gap; logic [39:0] resp;
        xfer(make_frame(6'd58, 32'h0), 5, gap, resp);
        n_checks++;
        if (resp !== 40'h00_C0FF_8000) begin
            $display("FAIL cmd58_ready_r3: got %h want 00c0ff8000", resp); n_fail++;
        end
    endtask

    task automatic test_abort;
        logic r; logic [47:0] f; int v0; logic [7:0] gap; logic [39:0] resp;
        f  = 48'h48_0000_01AA_87;
        v0 = valid_cnt;
        bus.cs_n = 1'b0;
        #(2 * HALF);
        for (int i = 47; i >= 29; i--) spi_bit(f[i], r);
        bus.mosi = f[28];
        #20;
        bus.cs_n = 1'b1;
        #30;
        bus.sclk = 1'b1;
        #HALF;
        bus.sclk = 1'b0;
        // Clocks with cs_n high and mosi low must not start a frame
        for (int i = 0; i < 8; i++) spi_bit(1'b0, r);
        bus.mosi = 1'b1;
        #(4 * HALF);
        n_checks++;
        if (valid_cnt !== v0) begin
            $display("FAIL abort_no_valid: got %0d pulses want 0", valid_cnt - v0); n_fail++;
        end
        n_checks++;
        if (bus.miso !== 1'b1) begin
            $display("FAIL abort_miso: got %b want 1", bus.miso); n_fail++;
        end
        n_checks++;
        if (bus.card_ready !== 1'b1) begin
            $display("FAIL abort_state_kept: got %b want 1", bus.card_ready); n_fail++;
        end
        xfer(48'h40_0000_0000_95, 1, gap, resp);
        n_checks++;
        if (resp[7:0] !== 8'h01) begin
            $display("FAIL abort_cmd0_r1: got %h want 01", resp[7:0]); n_fail++;
        end
        n_checks++;
        if (bus.card_ready !== 1'b0) begin
            $display("FAIL abort_cmd0_ready: got %b want 0", bus.card_ready); n_fail++;
        end
        n_checks++;
        if (valid_cnt !== v0 + 1) begin
            $display("FAIL abort_cmd0_valid: got %0d pulses want 1", valid_cnt - v0); n_fail++;
        end
    endtask

    task automatic test_rst_mid_frame;
        logic r; logic [47:0] f; int v0; logic [7:0] gap; logic [39:0] resp;
        xfer(make_frame(6'd55, 32'h0), 1, gap, resp);
        f  = make_frame(6'd58, 32'h0);
        v0 = valid_cnt;
        bus.cs_n = 1'b0;
        #(2 * HALF);
        for (int i = 47; i >= 18; i--) spi_bit(f[i], r);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b1;
        #(4 * HALF);
        n_checks++;
        if (valid_cnt !== v0) begin
            $display("FAIL rst_no_valid: got %0d pulses want 0", valid_cnt - v0); n_fail++;
        end
        n_checks++;
        if (bus.miso !== 1'b1) begin
            $display("FAIL rst_miso: got %b want 1", bus.miso); n_fail++;
        end
        n_checks++;
        if (bus.cmd_index !== 6'd0) begin
            $display("FAIL rst_cmd_index: got %0d want 0", bus.cmd_index); n_fail++;
        end
        // App flag from the CMD55 above must be gone
        xfer(make_frame(6'd41, 32'h4000_0000), 1, gap, resp);
        n_checks++;
        if (resp[7:0] !== 8'h05) begin
            $display("FAIL rst_app_cleared: got %h want 05", resp[7:0]); n_fail++;
        end
    endtask

    initial begin
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b1;
        test_reset();
        test_cmd0();
        test_cmd8();
        test_cmd58_idle();
        test_illegal();
        test_app_clear();
        test_acmd41();
        test_cmd58_ready();
        test_abort();
        test_rst_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_spi_responder.md
SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 SHALL have parameter BUSY_COUNT, default 2, the number of ACMD41s answered "busy" (R1=0x01) before the card reports ready.
REQ-002 SHALL have parameter OCR_VOLT, default 24'hFF8000, the OCR voltage window bits [23:0] returned in R3.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have port sclk, input, 1 bit, the SPI clock from the host (asynchronous; mode 0).
REQ-006 SHALL have port cs_n, input, 1 bit, the active-low chip select from the host (asynchronous).
REQ-007 SHALL have port mosi, input, 1 bit, the host-to-card data (asynchronous).
REQ-008 SHALL have port miso, output, 1 bit, the card-to-host data, registered.
REQ-009 SHALL have port cmd_valid, output, 1 bit, a one-clk pulse when a 48-bit command frame completes.
REQ-010 SHALL have port cmd_index, output, 6 bits, the index of the last completed command, held until the next one.
REQ-011 SHALL have port cmd_arg, output, 32 bits, the argument of the last completed command, held until the next one.
REQ-012 SHALL have port card_ready, output, 1 bit, a level that is 1 once initialization has completed (idle bit cleared).

Function
REQ-013 SHALL synchronize sclk, cs_n and mosi through 2 flops each, and SHALL detect sclk rising and falling edges on the synchronized signal; correct operation requires an sclk period of at least 8 clk.
REQ-014 SHALL sample mosi on synchronized sclk rising edges only, and SHALL update miso only on synchronized falling edges, MSB first.
REQ-015 SHALL implement FSM states HUNT, CMD, GAP and RESP.
REQ-016 SHALL behave as follows in HUNT: miso=1; a sampled 0 with cs_n low is the start bit, counted as bit 1 -> CMD.
REQ-017 SHALL behave as follows in CMD: collect bits 2..48 into a 48-bit frame; frame = {0,1,index[5:0],arg[31:0],crc7,1}; the transmission bit, CRC and stop bit are ignored (no CRC check); after bit 48 -> GAP, with cmd_valid pulsed one clk after the bit-48 edge.
REQ-018 SHALL behave as follows in GAP: miso=1 for 8 rising edges (Ncr = 1 byte); response bit 0 is driven from the falling edge after the 8th gap rising edge -> RESP.
REQ-019 SHALL behave as follows in RESP: shift out 8 bits (R1) or 40 bits (R3/R7); after the last bit's rising edge, miso=1 -> HUNT.
REQ-020 SHALL form R1 as {0,0,0,0,0,illegal,0,idle}.
REQ-021 SHALL respond to CMD0 by setting idle=1, clearing the ACMD41 counter, clearing app and clearing card_ready; R1 = 0x01.
REQ-022 SHALL respond to CMD8 with R7 = R1, 0x00, 0x00, {4'h0,arg[11:8]}, arg[7:0].
REQ-023 SHALL respond to CMD55 with R1 and set app=1; app SHALL clear after the next completed command, whatever its index.
REQ-024 SHALL treat ACMD41 (CMD41 with app=1) as follows: while the counter < BUSY_COUNT, increment it and reply R1 = 0x01; otherwise clear idle, set card_ready and reply R1 = 0x00.
REQ-025 SHALL treat CMD41 with app=0 as illegal.
REQ-026 SHALL respond to CMD58 with R3 = R1, then OCR = {card_ready,card_ready,6'h0,OCR_VOLT}; with card_ready=1 the first OCR byte is 0xC0 (CCS=1).
REQ-027 SHALL treat any other index as illegal: R1 = {5'b0,1,0,idle}.
REQ-028 SHALL, when cs_n goes high in any state, enter HUNT with miso=1 and assert no cmd_valid for the partial frame; no internal card state changes.
REQ-029 SHALL ignore sclk edges while cs_n is high (covers the ≥74 power-up clocks).
REQ-030 SHALL decide the response from the complete frame at bit 48; card-state updates SHALL take effect at the same time as cmd_valid.

Reset
REQ-031 SHALL, on rst=1 at a clk edge, set: FSM=HUNT, miso=1, cmd_valid=0, cmd_index=0, cmd_arg=0, card_ready=0, idle=1, app=0, ACMD41 counter=0, bit counters=0, synchronizers=1 (sclk sync=0).
REQ-032 SHALL, when rst is asserted mid-frame or mid-response, abort immediately and produce no cmd_valid.

Verification
REQ-033 SHALL be verified by: CMD0 frame 40 00 00 00 00 95 -> host reads FF, then 01; cmd_valid pulses once with cmd_index=0.
REQ-034 SHALL be verified by: CMD8 frame 48 00 00 01 AA 87 -> FF, 01 00 00 01 AA.
REQ-035 SHALL be verified by: with BUSY_COUNT=2, three CMD55+ACMD41 (arg 40000000) pairs -> ACMD41 R1 values 01, 01, 00; card_ready rises at the third.
REQ-036 SHALL be verified by: after ready, CMD58 -> 00 C0 FF 80 00; before ready, CMD58 -> 01 00 FF 80 00.
REQ-037 SHALL be verified by: CMD41 without CMD55 -> 05; CMD5 while idle -> 05.
REQ-038 SHALL be verified by: cs_n raised at bit 20 of a CMD8 -> no cmd_valid, miso=1; a following CMD0 -> 01.
